rom_mul_bcd: RTL and testbench

Single-digit BCD multiplier built around a 256-entry lookup ROM. It multiplies two BCD digits (0–9) and returns the product as a two-digit packed BCD value (00–81). The ROM is combinational and feeds one output register. The block serves as the arithmetic leaf for decimal datapaths and as the course's reference example of a ROM-based function.

---
 rtl/rom_mul_pkg.sv | 10 +
 rtl/rom_bcd_table.sv | 119 +++++++++++
 rtl/rom_mul_bcd.sv | 34 +++
 tb/tb_rom_mul_bcd.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rom_mul_pkg.sv
// Shared widths and constants for the ROM-based BCD digit multiplier.
package rom_mul_pkg;

  localparam int BCD_W  = 4;
  localparam int PROD_W = 8;

  // Returned for any address whose digit nibbles are not both 0-9.
  localparam logic [PROD_W-1:0] INVALID_PRODUCT = 8'h00;

endpackage

// File: rtl/rom_bcd_table.sv
// Combinational product ROM. The address is {x, y}. The data is the packed
// BCD product of the two digits, or INVALID_PRODUCT for a non-BCD digit.
module rom_bcd_table
  import rom_mul_pkg::*;
(
  input  logic [2*BCD_W-1:0] i_addr,
  output logic [PROD_W-1:0]  o_data
);

  // Fully enumerated table of the 100 legal digit pairs. Every other
  // address falls through to the default branch.
  always_comb begin
    o_data = INVALID_PRODUCT;
    case (i_addr)
      8'h00: o_data = 8'h00;
      8'h01: o_data = 8'h00;
      8'h02: o_data = 8'h00;
      8'h03: o_data = 8'h00;
      8'h04: o_data = 8'h00;
      8'h05: o_data = 8'h00;
      8'h06: o_data = 8'h00;
      8'h07: o_data = 8'h00;
      8'h08: o_data = 8'h00;
      8'h09: o_data = 8'h00;
      8'h10: o_data = 8'h00;
      8'h11: o_data = 8'h01;
      8'h12: o_data = 8'h02;
      8'h13: o_data = 8'h03;
      8'h14: o_data = 8'h04;
      8'h15: o_data = 8'h05;
      8'h16: o_data = 8'h06;
      8'h17: o_data = 8'h07;
      8'h18: o_data = 8'h08;
      8'h19: o_data = 8'h09;
      8'h20: o_data = 8'h00;
      8'h21: o_data = 8'h02;
      8'h22: o_data = 8'h04;
      8'h23: o_data = 8'h06;
      8'h24: o_data = 8'h08;
      8'h25: o_data = 8'h10;
      8'h26: o_data = 8'h12;
      8'h27: o_data = 8'h14;
      8'h28: o_data = 8'h16;
      8'h29: o_data = 8'h18;
      8'h30: o_data = 8'h00;
      8'h31: o_data = 8'h03;
      8'h32: o_data = 8'h06;
      8'h33: o_data = 8'h09;
      8'h34: o_data = 8'h12;
      8'h35: o_data = 8'h15;
      8'h36: o_data = 8'h18;
      8'h37: o_data = 8'h21;
      8'h38: o_data = 8'h24;
      8'h39: o_data = 8'h27;
      8'h40: o_data = 8'h00;
      8'h41: o_data = 8'h04;
      8'h42: o_data = 8'h08;
      8'h43: o_data = 8'h12;
      8'h44: o_data = 8'h16;
      8'h45: o_data = 8'h20;
      8'h46: o_data = 8'h24;
      8'h47: o_data = 8'h28;
      8'h48: o_data = 8'h32;
      8'h49: o_data = 8'h36;
      8'h50: o_data = 8'h00;
      8'h51: o_data = 8'h05;
      8'h52: o_data = 8'h10;
      8'h53: o_data = 8'h15;
      8'h54: o_data = 8'h20;
      8'h55: o_data = 8'h25;
      8'h56: o_data = 8'h30;
      8'h57: o_data = 8'h35;
      8'h58: o_data = 8'h40;
      8'h59: o_data = 8'h45;
      8'h60: o_data = 8'h00;
      8'h61: o_data = 8'h06;
      8'h62: o_data = 8'h12;
      8'h63: o_data = 8'h18;
      8'h64: o_data = 8'h24;
      8'h65: o_data = 8'h30;
      8'h66: o_data = 8'h36;
      8'h67: o_data = 8'h42;
      8'h68: o_data = 8'h48;
      8'h69: o_data = 8'h54;
      8'h70: o_data = 8'h00;
      8'h71: o_data = 8'h07;
      8'h72: o_data = 8'h14;
      8'h73: o_data = 8'h21;
      8'h74: o_data = 8'h28;
      8'h75: o_data = 8'h35;
      8'h76: o_data = 8'h42;
      8'h77: o_data = 8'h49;
      8'h78: o_data = 8'h56;
      8'h79: o_data = 8'h63;
      8'h80: o_data = 8'h00;
      8'h81: o_data = 8'h08;
      8'h82: o_data = 8'h16;
      8'h83: o_data = 8'h24;
      8'h84: o_data = 8'h32;
      8'h85: o_data = 8'h40;
      8'h86: o_data = 8'h48;
      8'h87: o_data = 8'h56;
      8'h88: o_data = 8'h64;
      8'h89: o_data = 8'h72;
      8'h90: o_data = 8'h00;
      8'h91: o_data = 8'h09;
      8'h92: o_data = 8'h18;
      8'h93: o_data = 8'h27;
      8'h94: o_data = 8'h36;
      8'h95: o_data = 8'h45;
      8'h96: o_data = 8'h54;
      8'h97: o_data = 8'h63;
      8'h98: o_data = 8'h72;
      8'h99: o_data = 8'h81;
      default: o_data = INVALID_PRODUCT;
    endcase
  end

endmodule

// File: rtl/rom_mul_bcd.sv
// Single-digit BCD multiplier: the product ROM followed by one output
// register. The latency is one cycle, and a new operand pair is accepted
// every cycle.
module rom_mul_bcd
  import rom_mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BCD_W-1:0]  x,
  input  logic [BCD_W-1:0]  y,
  output logic [PROD_W-1:0] z
);

  logic [PROD_W-1:0] w_romData;
  logic [PROD_W-1:0] r_z;

  rom_bcd_table u_table (
    .i_addr (({x, y})),
    .o_data (w_romData)
  );

  // The register reloads on every edge and has no enable. The reset clears it
  // at once, so an in-flight product is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_z <= '0;
    end else begin
      r_z <= w_romData;
    end
  end

  assign z = r_z;

endmodule

// File: tb/tb_rom_mul_bcd.sv
// Self-checking bench for rom_mul_bcd. It uses a table of corner vectors, an
// exhaustive sweep with a reset in the middle, and random operands. All are
// compared against an arithmetic reference model.
module tb_rom_mul_bcd;

  logic       clk;
  logic       reset_n;
  logic [3:0] x;
  logic [3:0] y;
  logic [7:0] z;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [3:0] vx;
    logic [3:0] vy;
    logic [7:0] expected;
    string      name;
  } vec_t;

  vec_t vecs[$];

  rom_mul_bcd dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .z       (z)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the decimal product split into tens and units, or zero if
  // either digit is not BCD.
  function automatic logic [7:0] refProduct(input int a, input int b);
    int p;
    if (a > 9 || b > 9) return 8'h00;
    p = a * b;
    return 8'((p / 10) * 16 + (p % 10));
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: z=%h expected %h", name, actual, expected);
    end
  endtask

  // Drive the operands away from the rising edge, then sample just after it.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    x = a;
    y = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ok;
    logic [7:0] e;
    testsRun    = 0;
    testsFailed = 0;
    reset_n     = 1'b1;
    x           = 4'd0;
    y           = 4'd0;

    vecs.push_back('{4'd9,  4'd9,  8'h81, "corner_9x9"});
    vecs.push_back('{4'd0,  4'd9,  8'h00, "corner_0x9"});
    vecs.push_back('{4'd5,  4'd2,  8'h10, "corner_5x2"});
    vecs.push_back('{4'd6,  4'd7,  8'h42, "corner_6x7"});
    vecs.push_back('{4'd9,  4'd1,  8'h09, "corner_9x1"});
    vecs.push_back('{4'd10, 4'd3,  8'h00, "illegal_10x3"});
    vecs.push_back('{4'd3,  4'd15, 8'h00, "illegal_3x15"});
    vecs.push_back('{4'd15, 4'd15, 8'h00, "illegal_15x15"});
    vecs.push_back('{4'd8,  4'd8,  8'h64, "corner_8x8"});

    // Reset held: the clock edges must not load the 7*8 product.
    #1;
    reset_n = 1'b0;
    x = 4'd7;
    y = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", z, 8'h00);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release_7x8", z, 8'h56);

    // Table of corner vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].vx, vecs[i].vy);
      checkOutput(vecs[i].name, z, vecs[i].expected);
    end

    // Back-to-back operands. Before the edge, z still shows the old product.
    applyStimulus(4'd7, 4'd8);
    checkOutput("b2b_7x8", z, 8'h56);
    @(negedge clk);
    x = 4'd4;
    y = 4'd4;
    #1;
    checkOutput("b2b_latency_hold", z, 8'h56);
    @(posedge clk);
    #1;
    checkOutput("b2b_4x4", z, 8'h16);
    applyStimulus(4'd9, 4'd3);
    checkOutput("b2b_9x3", z, 8'h27);

    // Exhaustive legal sweep. A reset is pulsed partway through.
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        applyStimulus(4'(a), 4'(b));
        ok = ((int'(z[7:4]) * 10 + int'(z[3:0])) == a * b) &&
             (z[7:4] <= 4'd9) && (z[3:0] <= 4'd9);
        e = refProduct(a, b);
        checkOutput($sformatf("sweep_%0dx%0d", a, b), ok ? e : ~e, e);
        if (a == 5 && b == 5) begin
          #2;
          reset_n = 1'b0;
          #1;
          checkOutput("midstream_async_clear", z, 8'h00);
          @(posedge clk);
          #1;
          checkOutput("midstream_hold", z, 8'h00);
          @(negedge clk);
          reset_n = 1'b1;
        end
      end
    end

    // Random operands over the full nibble range, legal and illegal.
    for (int i = 0; i < 200; i++) begin
      int ra;
      int rb;
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      applyStimulus(4'(ra), 4'(rb));
      checkOutput($sformatf("rand_%0dx%0d", ra, rb), z, refProduct(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
